rr_mux13_arbiter: RTL and testbench
===================================

// Module: rr_mux13_arbiter
// PURPOSE
//  Round-robin arbiter that shares one 4-bit output channel among 13 requesters.
//  Drives the 4-bit select of a 13:1 x 4-bit mux and registers the chosen beat.
//  Hands the beat downstream over a valid/ready handshake.
//  Supports optional per-requester locked bursts, so a requester keeps the channel for consecutive beats.
// PARAMETERS
//  N          13          number of requesters
//  W          4           data bits per requester
//  SW         $clog2(N)   select / source-index width (4)
//  MAX_BURST  4           max beats one locked grant may hold the channel (>=1)
// PORTS
//  clk        in   1     clock, all state updates on rising edge
//  rst        in   1     synchronous, active-high reset
//  req_valid  in   N     requester i has a beat
//  req_data   in   N*W   requester i data at [W*i+W-1 : W*i]
//  req_lock   in   N     requester i asks to keep the grant after this beat
//  req_ready  out  N     one-hot (or zero): beat of requester i is accepted this cycle
//  out_valid  out  1     registered output beat valid
//  out_ready  in   1     downstream accepts out beat
//  out_data   out  W     registered selected data
//  out_src    out  SW    index of requester that produced out_data
//  sel        out  SW    current mux select (index being accepted / pointed at)
//  locked     out  1     FSM in LOCKED state
// BEHAVIOUR
//  Reset: out_valid=0, out_data=0, out_src=0, ptr=0, owner=0, beat_cnt=0, state=ARB, locked=0.
//   req_ready=0 while rst=1.
//  Slot free: can_acc = !out_valid | out_ready. No beat is accepted unless can_acc=1.
//  ARB state:
//   - pick = first i with req_valid[i], scanning ptr, ptr+1, ..., wrapping 12->0.
//   - If any req_valid and can_acc: req_ready[pick]=1, with accept in the same cycle (combinational ready).
//   - On accept: out_data<=req_data[pick], out_src<=pick, out_valid<=1.
//   - If req_lock[pick] and MAX_BURST>1: go LOCKED, owner<=pick, beat_cnt<=1, ptr unchanged.
//   - Otherwise ptr<=pick+1 (12 wraps to 0).
//  LOCKED state: only owner may be granted; req_ready[j]=0 for all j!=owner.
//   - Owner accepted (req_valid[owner] & can_acc): beat_cnt++.
//     - Return to ARB with ptr<=owner+1 if req_lock[owner]=0 or beat_cnt+1==MAX_BURST.
//   - Owner idle (can_acc & !req_valid[owner]): release to ARB with ptr<=owner+1, no transfer.
//   - can_acc=0: hold everything.
//  Output: out_valid cleared when out_ready & no new accept; held stable (data/src) while out_valid & !out_ready.
//  sel: pick in ARB, owner in LOCKED; combinational, data path = req_data[sel].
//  Latency: 1 cycle from accept to out_valid. Full throughput: 1 beat/cycle when out_ready=1.
//  No requests: req_ready=0, ptr unchanged.
//  rst mid-burst: LOCKED abandoned, pending out beat dropped, all state to reset values.
//  Fairness: in ARB each requester waits at most N-1 grants; a lock holds at most MAX_BURST beats.
// STRUCTURE
//  Shared package arb_pkg:
//   - typedef enum logic {ARB, LOCKED} arb_state_t
//   - constants N_REQ=13, REQ_W=4
//   - function wrap_inc(idx) for mod-N increment.
//  Sub-module rr_pick13: combinational rotate-priority picker.
//   - Inputs: req[N], ptr.
//   - Outputs: any, idx[SW].
//  Top holds the FSM, ptr, owner, beat_cnt and the output register; it instantiates the 13:1 x 4-bit mux driven by sel.
// TESTING
//  1. rst, then req_valid=13'h1FFF, out_ready=1, no lock
//     -> out_src sequence 0,1,...,12,0 on consecutive cycles.
//  2. ptr=12, only req 12 and 3 valid
//     -> grant 12 first, then 3 (wrap), ptr ends at 4.
//  3. req 5 lock=1 continuously, req 6 valid, MAX_BURST=4
//     -> four beats from 5, then 6; locked high for 3 cycles after first beat.
//  4. out_ready=0 with out_valid=1 for 3 cycles
//     -> req_ready=0, out_data/out_src stable; first beat resumes on out_ready=1.
//  5. LOCKED owner 2 drops req_valid
//     -> release next cycle, ptr=3, other requesters served.
//  6. rst asserted mid-burst with out_valid=1
//     -> next cycle out_valid=0, locked=0, ptr=0; first grant after rst goes to lowest valid index.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared constants, state type and index helper for the 13-way round-robin arbiter.
package arb_pkg;

    localparam int unsigned N_REQ = 13;
    localparam int unsigned REQ_W = 4;
    localparam int unsigned SEL_W = $clog2(N_REQ);

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Increment a requester index modulo N_REQ (12 wraps to 0).
    function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] idx);
        return (idx == SEL_W'(N_REQ - 1)) ? '0 : idx + SEL_W'(1);
    endfunction

endpackage

// File: rtl/rr_pick13.sv
// Rotate-priority picker: first asserted request starting at ptr, wrapping 12->0.
module rr_pick13
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx
);

    localparam int unsigned SW = SEL_W;
    localparam int unsigned N  = N_REQ;

    logic [SW:0] pos;

    // Scan from the farthest offset down so the closest-to-ptr request wins.
    always_comb begin
        any = 1'b0;
        idx = '0;
        pos = '0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            pos = {1'b0, ptr} + (SW+1)'(k);
            if (pos >= (SW+1)'(N)) begin
                pos = pos - (SW+1)'(N);
            end
            if (req[pos[SW-1:0]]) begin
                any = 1'b1;
                idx = pos[SW-1:0];
            end
        end
    end

endmodule

// File: rtl/rr_mux13_arbiter.sv
// Round-robin arbiter sharing one 4-bit registered output channel among 13
// requesters, with optional locked bursts of up to MAX_BURST beats.
module rr_mux13_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned MAX_BURST = 4
)
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*REQ_W-1:0] req_data,
    input  logic [N_REQ-1:0]       req_lock,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [REQ_W-1:0]       out_data,
    output logic [SEL_W-1:0]       out_src,
    output logic [SEL_W-1:0]       sel,
    output logic                   locked
);

    localparam int unsigned N        = N_REQ;
    localparam int unsigned W        = REQ_W;
    localparam int unsigned SW       = SEL_W;
    localparam int unsigned CNT_W    = $clog2(MAX_BURST + 1);
    localparam bit          BURST_EN = (MAX_BURST > 1);

    arb_state_t       state;
    logic [SW-1:0]    ptr;
    logic [SW-1:0]    owner;
    logic [CNT_W-1:0] beat_cnt;

    logic             pick_any;
    logic [SW-1:0]    pick_idx;
    logic             can_acc;
    logic             accept;
    logic [W-1:0]     mux_data;

    rr_pick13 u_pick (
        .req (req_valid),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign can_acc = !out_valid || out_ready;
    assign sel     = (state == LOCKED) ? owner : pick_idx;
    assign accept  = !rst && can_acc &&
                     ((state == LOCKED) ? req_valid[owner] : pick_any);
    assign locked  = (state == LOCKED);

    // 13:1 x 4-bit data mux driven by sel.
    always_comb begin
        mux_data = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (sel == SW'(i)) begin
                mux_data = req_data[i*W +: W];
            end
        end
    end

    // One-hot ready to the requester whose beat is taken this cycle.
    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[sel] = 1'b1;
        end
    end

    // Arbitration FSM, rotation pointer, burst tracking and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ARB;
            ptr       <= '0;
            owner     <= '0;
            beat_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= mux_data;
                out_src   <= sel;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                ARB: begin
                    if (accept) begin
                        if (BURST_EN && req_lock[pick_idx]) begin
                            state    <= LOCKED;
                            owner    <= pick_idx;
                            beat_cnt <= CNT_W'(1);
                        end else begin
                            ptr <= wrap_inc(pick_idx);
                        end
                    end
                end
                LOCKED: begin
                    if (can_acc) begin
                        if (req_valid[owner]) begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                            if (!req_lock[owner] ||
                                (beat_cnt + CNT_W'(1)) == CNT_W'(MAX_BURST)) begin
                                state    <= ARB;
                                ptr      <= wrap_inc(owner);
                                beat_cnt <= '0;
                            end
                        end else begin
                            // Owner went idle: give the channel back.
                            state    <= ARB;
                            ptr      <= wrap_inc(owner);
                            beat_cnt <= '0;
                        end
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_mux13_arbiter.sv
// Randomised scoreboard bench for rr_mux13_arbiter with a behavioural model.
module tb_rr_mux13_arbiter;

    localparam int NR  = 13;
    localparam int DW  = 4;
    localparam int MB  = 4;

    logic              clk;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_lock;
    logic [NR-1:0]     req_ready;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic [3:0]        out_src;
    logic [3:0]        sel;
    logic              locked;

    rr_mux13_arbiter #(.MAX_BURST(MB)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_lock  (req_lock),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .sel       (sel),
        .locked    (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int src;
        int data;
    } beat_t;

    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    bit    done  = 0;

    // Model state: next requester in rotation, lock holder (-1 = none), beats
    // taken by the holder, and whether the output slot holds an undelivered beat.
    int m_next   = 0;
    int m_holder = -1;
    int m_beats  = 0;
    bit m_occ    = 0;

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, expv);
        end
    endtask

    function automatic int data_of(input int i);
        logic [NR*DW-1:0] d;
        d = req_data >> (DW * i);
        return int'(d[DW-1:0]);
    endfunction

    // Reference model: decides this cycle's grant from the arbitration rules.
    initial begin
        int  cand;
        bit  can;
        bit  granted;
        int  exp_ready;
        forever begin
            @(negedge clk);
            #2;
            if (done) break;
            if (rst) begin
                chk("ready_in_reset", int'(req_ready), 0);
                m_next = 0; m_holder = -1; m_beats = 0; m_occ = 0;
                exp_q.delete();
            end else begin
                chk("out_valid", int'(out_valid), int'(m_occ));
                chk("locked", int'(locked), (m_holder >= 0) ? 1 : 0);
                can  = !m_occ || out_ready;
                cand = -1;
                if (m_holder >= 0) begin
                    if (req_valid[m_holder]) cand = m_holder;
                end else begin
                    for (int k = 0; k < NR; k++) begin
                        if (cand < 0 && req_valid[(m_next + k) % NR]) cand = (m_next + k) % NR;
                    end
                end
                granted   = can && (cand >= 0);
                exp_ready = granted ? (1 << cand) : 0;
                chk("req_ready", int'(req_ready), exp_ready);

                if (m_holder >= 0 && can && !req_valid[m_holder]) begin
                    m_next   = (m_holder + 1) % NR;
                    m_holder = -1;
                end

                if (granted) begin
                    beat_t b;
                    b.src  = cand;
                    b.data = data_of(cand);
                    exp_q.push_back(b);
                    m_occ = 1;
                    if (m_holder < 0) begin
                        if (req_lock[cand] && MB > 1) begin
                            m_holder = cand;
                            m_beats  = 1;
                        end else begin
                            m_next = (cand + 1) % NR;
                        end
                    end else begin
                        m_beats++;
                        if (!req_lock[cand] || m_beats == MB) begin
                            m_next   = (cand + 1) % NR;
                            m_holder = -1;
                        end
                    end
                end else if (out_ready) begin
                    m_occ = 0;
                end
            end
        end
    end

    // Monitor: on each downstream handshake, pop and compare the delivered beat.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (done) break;
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    beat_t b;
                    b = exp_q.pop_front();
                    chk("out_src", int'(out_src), b.src);
                    chk("out_data", int'(out_data), b.data);
                end
            end
        end
    end

    task automatic step(input logic [NR-1:0] v, input logic [NR-1:0] l,
                        input logic r, input logic rs);
        @(negedge clk);
        req_valid = v;
        req_lock  = l;
        out_ready = r;
        rst       = rs;
        req_data  = {$urandom, $urandom};
    endtask

    task automatic steps(input int n, input logic [NR-1:0] v, input logic [NR-1:0] l,
                         input logic r);
        for (int i = 0; i < n; i++) step(v, l, r, 1'b0);
    endtask

    // Directed scenarios followed by random traffic and a drain.
    initial begin
        rst = 1'b1; req_valid = '0; req_lock = '0; out_ready = 1'b0; req_data = '0;
        step('0, '0, 1'b0, 1'b1);
        step('0, '0, 1'b0, 1'b1);

        // Full rotation with all requesters valid.
        steps(15, 13'h1FFF, '0, 1'b1);

        // Move pointer to 12, then 12 and 3 compete across the wrap.
        step('0, '0, 1'b1, 1'b1);
        step(13'h0800, '0, 1'b1, 1'b0);
        steps(4, 13'h1008, '0, 1'b1);

        // Locked burst from 5 against 6.
        steps(8, 13'h0060, 13'h0020, 1'b1);

        // Downstream stall with traffic pending.
        step(13'h0F0F, '0, 1'b1, 1'b0);
        steps(3, 13'h0F0F, '0, 1'b0);
        steps(3, 13'h0F0F, '0, 1'b1);

        // Lock owner 2 goes idle mid-burst.
        steps(2, 13'h0004, 13'h0004, 1'b1);
        steps(3, 13'h0130, '0, 1'b1);

        // Reset while locked with a beat pending.
        steps(2, 13'h0080, 13'h0080, 1'b0);
        step(13'h0080, 13'h0080, 1'b1, 1'b1);
        steps(3, 13'h0A42, '0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(13'($urandom) & (($urandom_range(0, 3) == 0) ? 13'($urandom) : 13'h1FFF),
                 13'($urandom) & 13'($urandom),
                 ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 299) == 0));
        end

        // Drain.
        steps(8, '0, '0, 1'b1);
        @(negedge clk);
        #4;
        done = 1;
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
